// File: rtl/mesh_pkg.sv
// ============================================================================
// Module      : mesh_pkg
// Description : Packet field layout, terminal FSM states and echo builder
//               shared by the mesh terminal endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mesh_pkg;

    // Header occupies the top 25 bits of every packet; payload is the rest.
    localparam int c_HDR_W       = 25;
    localparam int c_NXT_W       = 8;
    localparam int c_ID_W        = 4;
    localparam int c_HDR_NXT_LSB  = 17;
    localparam int c_HDR_DROW_LSB = 13;
    localparam int c_HDR_DCOL_LSB = 9;
    localparam int c_HDR_MODE     = 8;
    localparam int c_HDR_SROW_LSB = 4;
    localparam int c_HDR_SCOL_LSB = 0;

    typedef logic [c_HDR_W-1:0] hdr_t;
    typedef logic [c_ID_W-1:0]  id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_EVAL = 2'd2
    } term_state_t;

    function automatic int payload_w(input int pckg_sz);
        return pckg_sz - c_HDR_W;
    endfunction

    function automatic int hdr_lsb(input int pckg_sz);
        return pckg_sz - c_HDR_W;
    endfunction

    // Response header: hop count cleared, source and destination swapped.
    function automatic hdr_t mk_echo(input hdr_t hdr, input id_t row, input id_t col);
        return {{c_NXT_W{1'b0}},
                hdr[c_HDR_SROW_LSB +: c_ID_W],
                hdr[c_HDR_SCOL_LSB +: c_ID_W],
                hdr[c_HDR_MODE],
                row,
                col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/term_fifo.sv
// ============================================================================
// Module      : term_fifo
// Description : First-word fall-through response queue with count and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_fifo #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [pckg_sz-1:0]                 push_data,
    input  logic                               pop,
    output logic [pckg_sz-1:0]                 head,
    output logic [$clog2(fifo_depth+1)-1:0]    count,
    output logic                               empty,
    output logic                               full
);

    localparam int c_PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int c_CNT_W = $clog2(fifo_depth + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(fifo_depth - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(fifo_depth);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign head  = w_empty ? '0 : r_mem[r_rptr];
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

endmodule

`default_nettype wire

// File: rtl/mesh_term_echo.sv
// ============================================================================
// Module      : mesh_term_echo
// Description : Mesh terminal that pops delivered packets and queues an echo
//               response for every packet addressed to its own coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_term_echo
    import mesh_pkg::*;
#(
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [3:0] ROW        = 4'd0,
    parameter logic [3:0] COL        = 4'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_pndng,
    input  logic [pckg_sz-1:0] rx_data,
    output logic               rx_pop,
    output logic               tx_pndng,
    output logic [pckg_sz-1:0] tx_data,
    input  logic               tx_popin,
    output logic [15:0]        echo_cnt,
    output logic [15:0]        drop_cnt
);

    localparam int c_PAY_W  = payload_w(pckg_sz);
    localparam int c_HDR_LSB = hdr_lsb(pckg_sz);
    localparam int c_CNT_W  = $clog2(fifo_depth + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(fifo_depth);
    localparam logic [15:0]        c_SAT   = 16'hFFFF;

    term_state_t        r_state;
    logic [pckg_sz-1:0] r_hold;
    logic [15:0]        r_echo_cnt;
    logic [15:0]        r_drop_cnt;

    hdr_t               w_hdr;
    logic               w_match;
    logic               w_push;
    logic [pckg_sz-1:0] w_echo;
    logic [c_CNT_W-1:0] w_count;
    logic               w_empty;
    logic               w_full;

    assign w_hdr   = r_hold[c_HDR_LSB +: c_HDR_W];
    assign w_match = (w_hdr[c_HDR_DROW_LSB +: c_ID_W] == ROW) &&
                     (w_hdr[c_HDR_DCOL_LSB +: c_ID_W] == COL);
    assign w_echo  = {mk_echo(w_hdr, ROW, COL), r_hold[c_PAY_W-1:0]};
    // The IDLE space check already guarantees room; the full guard is defensive.
    assign w_push  = (r_state == ST_EVAL) && w_match && !w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_echo_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_pndng && (w_count < c_DEPTH)) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (rx_pndng) begin
                        r_hold  <= rx_data;
                        r_state <= ST_EVAL;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    if (w_match) begin
                        if (r_echo_cnt != c_SAT) begin
                            r_echo_cnt <= r_echo_cnt + 16'd1;
                        end
                    end else if (r_drop_cnt != c_SAT) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    term_fifo #(
        .pckg_sz    (pckg_sz),
        .fifo_depth (fifo_depth)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_echo),
        .pop       (tx_popin),
        .head      (tx_data),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign rx_pop   = (r_state == ST_POP) && rx_pndng;
    assign tx_pndng = !w_empty;
    assign echo_cnt = r_echo_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mesh_term_echo.sv
// ============================================================================
// Module      : tb_mesh_term_echo
// Description : Directed scoreboard bench for the mesh terminal echo endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_term_echo;

    localparam int         P    = 52;
    localparam int         D    = 4;
    localparam logic [3:0] MY_R = 4'd1;
    localparam logic [3:0] MY_C = 4'd2;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         rx_pndng = 1'b0;
    logic [P-1:0] rx_data  = '0;
    logic         tx_popin = 1'b0;
    logic         rx_pop;
    logic         tx_pndng;
    logic [P-1:0] tx_data;
    logic [15:0]  echo_cnt;
    logic [15:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [P-1:0] sb [$];
    logic [P-1:0] mon_exp;
    logic [P-1:0] bp [6];
    logic [P-1:0] pk_a, pk_b, pk_c [4], pk_d [2];
    int           lat, idx, npop, n;

    mesh_term_echo #(
        .pckg_sz    (P),
        .fifo_depth (D),
        .ROW        (MY_R),
        .COL        (MY_C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_pndng (rx_pndng),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop),
        .tx_pndng (tx_pndng),
        .tx_data  (tx_data),
        .tx_popin (tx_popin),
        .echo_cnt (echo_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Fields: nxt_jmp(8) dst_r dst_c mode src_r src_c payload(27).
    function automatic logic [P-1:0] mk_pkt(input logic [3:0] dr, input logic [3:0] dc,
                                            input logic m, input logic [3:0] sr,
                                            input logic [3:0] sc, input logic [26:0] pl);
        return {8'hA5, dr, dc, m, sr, sc, pl};
    endfunction

    function automatic logic [P-1:0] exp_of(input logic [P-1:0] pk);
        return {8'h00, pk[34:31], pk[30:27], pk[35], MY_R, MY_C, pk[26:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: compare the head whenever the router consumes it.
    always @(negedge clk) begin
        if (!reset && tx_pndng && tx_popin) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected got=%h exp=none", tx_data);
            end else begin
                mon_exp = sb.pop_front();
                if (tx_data !== mon_exp) begin
                    failures++;
                    $display("FAIL tx_data got=%h exp=%h", tx_data, mon_exp);
                end
            end
        end
    end

    // Present one packet and hold it until popped; returns in the EVAL cycle.
    task automatic send_one(input logic [P-1:0] pk, input bit match, output int l);
        rx_data  = pk;
        rx_pndng = 1'b1;
        l = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_pop) begin
                l = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (l < 0) begin
            checks++;
            failures++;
            $display("FAIL rx_pop_timeout got=none exp=pulse");
        end else if (match) begin
            sb.push_back(exp_of(pk));
        end
        @(posedge clk); #1;
        rx_pndng = 1'b0;
    endtask

    task automatic router_step();
        @(negedge clk);
        if (rx_pop && idx < 6) begin
            sb.push_back(exp_of(bp[idx]));
            idx++;
            npop++;
        end
        @(posedge clk); #1;
        if (idx < 6) rx_data = bp[idx];
        else         rx_pndng = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pk_a = mk_pkt(4'd1, 4'd2, 1'b1, 4'd3, 4'd0, 27'h5A5A5A5);
        pk_b = mk_pkt(4'd0, 4'd0, 1'b0, 4'd5, 4'd6, 27'h0000123);
        for (int i = 0; i < 6; i++)
            bp[i] = mk_pkt(MY_R, MY_C, 1'(i), 4'(i), 4'(i + 1), 27'h100 + 27'(i));
        for (int i = 0; i < 4; i++)
            pk_c[i] = mk_pkt(MY_R, MY_C, 1'b0, 4'(8 + i), 4'(15 - i), 27'h7000 + 27'(i));
        pk_d[0] = mk_pkt(MY_R, MY_C, 1'b1, 4'd9, 4'd9, 27'h0ABCDEF);
        pk_d[1] = mk_pkt(MY_R, MY_C, 1'b0, 4'd4, 4'd7, 27'h0FEDCBA);

        // Reset, then 20 quiet cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {rx_pop, tx_pndng, tx_data, echo_cnt, drop_cnt}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outs", {rx_pop, tx_pndng, tx_data, echo_cnt, drop_cnt}, 64'd0);
            @(posedge clk); #1;
        end

        // Matching packet: pop at t+1, response visible at t+3.
        send_one(pk_a, 1'b1, lat);
        chk("match_pop_lat", 64'(lat), 64'd1);
        @(negedge clk);
        chk("match_tx_early", 64'(tx_pndng), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("match_tx_pndng", 64'(tx_pndng), 64'd1);
        chk("match_tx_data", 64'(tx_data),
            64'({8'h00, 4'd3, 4'd0, 1'b1, 4'd1, 4'd2, 27'h5A5A5A5}));
        chk("match_echo_cnt", 64'(echo_cnt), 64'd1);
        @(posedge clk); #1;
        tx_popin = 1'b1;
        @(posedge clk); #1;
        tx_popin = 1'b0;
        @(negedge clk);
        chk("match_drained", 64'(tx_pndng), 64'd0);
        @(posedge clk); #1;

        // Misrouted packet.
        send_one(pk_b, 1'b0, lat);
        chk("drop_pop_lat", 64'(lat), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_tx_pndng", 64'(tx_pndng), 64'd0);
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
        chk("drop_echo_cnt", 64'(echo_cnt), 64'd1);
        @(posedge clk); #1;

        // Back-pressure: six packets offered, only four fit.
        idx = 0; npop = 0;
        rx_data = bp[0];
        rx_pndng = 1'b1;
        repeat (30) router_step();
        chk("bp_pop_count", 64'(npop), 64'd4);
        chk("bp_tx_pndng", 64'(tx_pndng), 64'd1);
        tx_popin = 1'b1;
        @(negedge clk);
        chk("bp_hold_c0", 64'(rx_pop), 64'd0);
        @(posedge clk); #1;
        tx_popin = 1'b0;
        @(negedge clk);
        chk("bp_hold_c1", 64'(rx_pop), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_5th_pop", 64'(rx_pop), 64'd1);
        if (rx_pop) begin
            sb.push_back(exp_of(bp[idx]));
            idx++;
            npop++;
        end
        @(posedge clk); #1;
        rx_data = bp[idx];
        tx_popin = 1'b1;
        repeat (30) router_step();
        tx_popin = 1'b0;
        chk("bp_total_pops", 64'(npop), 64'd6);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        chk("bp_echo_cnt", 64'(echo_cnt), 64'd7);

        // Push and pop in the same EVAL cycle with three entries queued.
        for (int i = 0; i < 3; i++) send_one(pk_c[i], 1'b1, lat);
        repeat (2) @(posedge clk);
        #1;
        send_one(pk_c[3], 1'b1, lat);
        tx_popin = 1'b1;
        @(posedge clk); #1;
        tx_popin = 1'b0;
        @(negedge clk);
        chk("simul_head", 64'(tx_data), 64'(exp_of(pk_c[1])));
        @(posedge clk); #1;
        n = 0;
        tx_popin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tx_pndng) n++;
            @(posedge clk); #1;
        end
        tx_popin = 1'b0;
        chk("simul_count", 64'(n), 64'd3);
        chk("simul_sb_empty", 64'(sb.size()), 64'd0);
        chk("simul_echo_cnt", 64'(echo_cnt), 64'd11);

        // Reset during EVAL with one response already queued.
        send_one(pk_d[0], 1'b1, lat);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pre_pndng", 64'(tx_pndng), 64'd1);
        send_one(pk_d[1], 1'b1, lat);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("rst_tx_pndng", 64'(tx_pndng), 64'd0);
        chk("rst_counters", 64'({echo_cnt, drop_cnt}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_after", 64'({tx_pndng, rx_pop, echo_cnt, drop_cnt}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
